// File: rtl/pc_sequencer_pkg.sv
// Shared encodings for the fetch-side PC sequencer: FSM states, redirect types,
// next-PC select codes and sticky error bit positions.
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_BUBBLE = 2'd2,
        ST_HALTED = 2'd3
    } state_e;

    localparam logic [1:0] REDIR_ABS = 2'b01;
    localparam logic [1:0] REDIR_REL = 2'b10;

    localparam logic [1:0] SEL_SEQ = 2'b00;
    localparam logic [1:0] SEL_ABS = 2'b01;
    localparam logic [1:0] SEL_REL = 2'b10;

    localparam int ERR_TYPE  = 0;
    localparam int ERR_ALIGN = 1;

    function automatic logic redir_type_legal(input logic [1:0] t);
        return (t == REDIR_ABS) || (t == REDIR_REL);
    endfunction

endpackage

// File: rtl/pc_sequencer_next_pc_calc.sv
// Combinational three-way next-PC adjust: sequential step, absolute target,
// or PC-relative branch (base + STEP + signed offset), all modulo 2^WIDTH.
module next_pc_calc
    import pc_sequencer_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int STEP  = 4
) (
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] offset,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] next_pc
);

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    always_comb begin
        next_pc = pc + STEP_W;
        case (sel)
            SEL_SEQ: next_pc = pc + STEP_W;
            SEL_ABS: next_pc = offset;
            // Two's-complement offset: plain modular addition handles negatives.
            SEL_REL: next_pc = base + STEP_W + offset;
            default: next_pc = pc + STEP_W;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Owns the architectural PC and presents one fetch PC at a time over valid/ready;
// handles start-up, redirect flush bubbles, halt and sticky error flags.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int              WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter int              STEP      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             halt,
    output logic             fetch_valid,
    output logic [WIDTH-1:0] fetch_pc,
    input  logic             fetch_ready,
    input  logic             redir_valid,
    input  logic [1:0]       redir_type,
    input  logic [WIDTH-1:0] redir_target,
    input  logic [WIDTH-1:0] redir_pc,
    output logic             redir_ready,
    output logic             flush,
    output logic [15:0]      fetch_count,
    output logic [1:0]       err,
    output logic             halted,
    output logic [1:0]       dbg_state_o
);

    // Handshakes: a fetch transfer happens on a rising edge where
    // fetch_valid && fetch_ready; a redirect is consumed on an edge where
    // redir_valid && redir_ready. Neither valid may depend on its ready.

    state_e           state_q;
    logic             fetch_valid_q;
    logic [WIDTH-1:0] fetch_pc_q;
    logic             flush_q;
    logic [15:0]      count_q;
    logic [1:0]       err_q;
    logic             halted_q;
    logic             halt_pending_q;

    logic             xfer;
    logic             accept;
    logic             legal;
    logic [1:0]       sel;
    logic [WIDTH-1:0] calc_pc;
    logic [WIDTH-1:0] aligned_pc;
    logic             misaligned;

    assign redir_ready = (state_q == ST_RUN) || (state_q == ST_BUBBLE);
    assign xfer        = fetch_valid_q && fetch_ready;
    assign accept      = redir_valid && redir_ready;
    assign legal       = accept && redir_type_legal(redir_type);

    always_comb begin
        sel = SEL_SEQ;
        if (legal) sel = (redir_type == REDIR_ABS) ? SEL_ABS : SEL_REL;
    end

    next_pc_calc #(.WIDTH(WIDTH), .STEP(STEP)) u_calc (
        .pc      (fetch_pc_q),
        .base    (redir_pc),
        .offset  (redir_target),
        .sel     (sel),
        .next_pc (calc_pc)
    );

    assign misaligned = |calc_pc[1:0];
    assign aligned_pc = {calc_pc[WIDTH-1:2], 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            fetch_valid_q  <= 1'b0;
            fetch_pc_q     <= RESET_VEC;
            flush_q        <= 1'b0;
            count_q        <= '0;
            err_q          <= '0;
            halted_q       <= 1'b0;
            halt_pending_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q       <= ST_RUN;
                        fetch_valid_q <= 1'b1;
                    end
                end
                ST_RUN, ST_BUBBLE: begin
                    if (halt) halt_pending_q <= 1'b1;
                    if (xfer) count_q <= count_q + 16'd1;
                    if (accept && !legal) err_q[ERR_TYPE] <= 1'b1;
                    // A legal redirect beats both the sequential step and halt.
                    if (legal) begin
                        fetch_pc_q    <= aligned_pc;
                        if (misaligned) err_q[ERR_ALIGN] <= 1'b1;
                        state_q       <= ST_BUBBLE;
                        fetch_valid_q <= 1'b0;
                        flush_q       <= 1'b1;
                    end else if (state_q == ST_BUBBLE) begin
                        state_q       <= ST_RUN;
                        fetch_valid_q <= 1'b1;
                        flush_q       <= 1'b0;
                    end else if (xfer) begin
                        fetch_pc_q <= calc_pc;
                        if (halt_pending_q || halt) begin
                            state_q       <= ST_HALTED;
                            fetch_valid_q <= 1'b0;
                            halted_q      <= 1'b1;
                        end
                    end
                end
                ST_HALTED: begin
                end
                default: begin
                    state_q       <= ST_IDLE;
                    fetch_valid_q <= 1'b0;
                    flush_q       <= 1'b0;
                end
            endcase
        end
    end

    assign fetch_valid = fetch_valid_q;
    assign fetch_pc    = fetch_pc_q;
    assign flush       = flush_q;
    assign fetch_count = count_q;
    assign err         = err_q;
    assign halted      = halted_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, a reset-mid-bubble sequence,
// and randomized traffic checked against a rule-level reference model.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, halt, fetch_ready, redir_valid;
    logic [1:0]  redir_type;
    logic [15:0] redir_target, redir_pc;
    logic        fetch_valid, redir_ready, flush, halted;
    logic [15:0] fetch_pc, fetch_count;
    logic [1:0]  err, dbg_state;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .halt         (halt),
        .fetch_valid  (fetch_valid),
        .fetch_pc     (fetch_pc),
        .fetch_ready  (fetch_ready),
        .redir_valid  (redir_valid),
        .redir_type   (redir_type),
        .redir_target (redir_target),
        .redir_pc     (redir_pc),
        .redir_ready  (redir_ready),
        .flush        (flush),
        .fetch_count  (fetch_count),
        .err          (err),
        .halted       (halted),
        .dbg_state_o  (dbg_state)
    );

    typedef struct {
        logic        start, halt, ready, rv;
        logic [1:0]  rtype;
        logic [15:0] rtgt, rpc;
        logic        e_valid;
        logic [15:0] e_pc;
        logic        e_flush;
        logic [15:0] e_cnt;
        logic [1:0]  e_err;
        logic        e_halted, e_rr;
    } vec_t;

    vec_t vecs[$];

    // Compare all outputs at once; fetch_pc is only meaningful outside HALTED.
    task automatic check_out(input string name, input logic v, input logic [15:0] pc,
                             input logic f, input logic [15:0] cnt, input logic [1:0] e,
                             input logic h, input logic rr, input logic cmp_pc);
        checks++;
        if (fetch_valid !== v || flush !== f || fetch_count !== cnt || err !== e ||
            halted !== h || redir_ready !== rr || (cmp_pc && fetch_pc !== pc)) begin
            failures++;
            $display("FAIL %s: got v=%b pc=%h fl=%b cnt=%0d err=%b h=%b rr=%b want v=%b pc=%h fl=%b cnt=%0d err=%b h=%b rr=%b",
                     name, fetch_valid, fetch_pc, flush, fetch_count, err, halted, redir_ready,
                     v, pc, f, cnt, e, h, rr);
        end
    endtask

    task automatic drive(input logic st, hl, rdy, rv, input logic [1:0] ty,
                         input logic [15:0] tg, rp);
        start = st; halt = hl; fetch_ready = rdy; redir_valid = rv;
        redir_type = ty; redir_target = tg; redir_pc = rp;
    endtask

    task automatic idle_inputs();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0, 16'h0);
    endtask

    task automatic add(input logic st, hl, rdy, rv, input logic [1:0] ty,
                       input logic [15:0] tg, rp, input logic v, input logic [15:0] pc,
                       input logic f, input logic [15:0] cnt, input logic [1:0] e,
                       input logic h, rr);
        vec_t x;
        x.start = st; x.halt = hl; x.ready = rdy; x.rv = rv; x.rtype = ty;
        x.rtgt = tg; x.rpc = rp; x.e_valid = v; x.e_pc = pc; x.e_flush = f;
        x.e_cnt = cnt; x.e_err = e; x.e_halted = h; x.e_rr = rr;
        vecs.push_back(x);
    endtask

    // Reference model: phases named by what the fetch port is doing.
    localparam int PH_IDLE = 0, PH_FETCH = 1, PH_GAP = 2, PH_STOP = 3;
    int          m_phase;
    logic [15:0] m_pc, m_cnt;
    logic [1:0]  m_err;
    bit          m_pend;

    task automatic model_reset();
        m_phase = PH_IDLE; m_pc = 16'h0000; m_cnt = 0; m_err = 0; m_pend = 0;
    endtask

    task automatic model_step(input logic st, hl, rdy, rv, input logic [1:0] ty,
                              input logic [15:0] tg, rp);
        bit live  = (m_phase == PH_FETCH) || (m_phase == PH_GAP);
        bit moved = (m_phase == PH_FETCH) && rdy;
        bit take  = live && rv;
        bit good  = take && (ty == 2'b01 || ty == 2'b10);
        logic [15:0] dest;
        if (m_phase == PH_IDLE) begin
            if (st) m_phase = PH_FETCH;
            return;
        end
        if (!live) return;
        if (hl) m_pend = 1;
        if (moved) m_cnt = m_cnt + 1;
        if (take && !good) m_err[0] = 1'b1;
        if (good) begin
            dest = (ty == 2'b01) ? tg : rp + 16'd4 + tg;
            if (dest % 4 != 0) m_err[1] = 1'b1;
            m_pc = dest & 16'hFFFC;
            m_phase = PH_GAP;
        end else if (m_phase == PH_GAP) begin
            m_phase = PH_FETCH;
        end else if (moved) begin
            m_pc = m_pc + 16'd4;
            if (m_pend) m_phase = PH_STOP;
        end
    endtask

    task automatic check_model(input string name);
        check_out(name, m_phase == PH_FETCH, m_pc, m_phase == PH_GAP, m_cnt, m_err,
                  m_phase == PH_STOP, m_phase == PH_FETCH || m_phase == PH_GAP,
                  m_phase != PH_STOP);
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        #12;
        check_out("reset", 0, 16'h0000, 0, 0, 2'b00, 0, 0, 1);
        @(posedge clk); #1; rst = 1'b0;

        //  st hl rdy rv ty     tgt       rpc       v  pc        f cnt err   h rr
        add(1, 0, 0, 0, 2'b00, 16'h0000, 16'h0000, 1, 16'h0000, 0, 0, 2'b00, 0, 1);
        add(0, 0, 1, 0, 2'b00, 16'h0000, 16'h0000, 1, 16'h0004, 0, 1, 2'b00, 0, 1);
        add(0, 0, 1, 0, 2'b00, 16'h0000, 16'h0000, 1, 16'h0008, 0, 2, 2'b00, 0, 1);
        add(0, 0, 0, 0, 2'b00, 16'h0000, 16'h0000, 1, 16'h0008, 0, 2, 2'b00, 0, 1);
        add(0, 0, 0, 0, 2'b00, 16'h0000, 16'h0000, 1, 16'h0008, 0, 2, 2'b00, 0, 1);
        add(0, 0, 0, 0, 2'b00, 16'h0000, 16'h0000, 1, 16'h0008, 0, 2, 2'b00, 0, 1);
        add(0, 0, 1, 0, 2'b00, 16'h0000, 16'h0000, 1, 16'h000C, 0, 3, 2'b00, 0, 1);
        add(0, 0, 1, 0, 2'b00, 16'h0000, 16'h0000, 1, 16'h0010, 0, 4, 2'b00, 0, 1);
        add(0, 0, 1, 1, 2'b01, 16'hFFF8, 16'h0000, 0, 16'hFFF8, 1, 5, 2'b00, 0, 1);
        add(0, 0, 1, 0, 2'b00, 16'h0000, 16'h0000, 1, 16'hFFF8, 0, 5, 2'b00, 0, 1);
        add(0, 0, 1, 0, 2'b00, 16'h0000, 16'h0000, 1, 16'hFFFC, 0, 6, 2'b00, 0, 1);
        add(0, 0, 1, 0, 2'b00, 16'h0000, 16'h0000, 1, 16'h0000, 0, 7, 2'b00, 0, 1);
        add(0, 0, 1, 0, 2'b00, 16'h0000, 16'h0000, 1, 16'h0004, 0, 8, 2'b00, 0, 1);
        add(0, 0, 1, 0, 2'b00, 16'h0000, 16'h0000, 1, 16'h0008, 0, 9, 2'b00, 0, 1);
        add(0, 0, 0, 1, 2'b10, 16'hFFF0, 16'h0010, 0, 16'h0004, 1, 9, 2'b00, 0, 1);
        add(0, 0, 0, 0, 2'b00, 16'h0000, 16'h0000, 1, 16'h0004, 0, 9, 2'b00, 0, 1);
        add(0, 0, 0, 1, 2'b11, 16'h0100, 16'h0000, 1, 16'h0004, 0, 9, 2'b01, 0, 1);
        add(0, 0, 1, 0, 2'b00, 16'h0000, 16'h0000, 1, 16'h0008, 0, 10, 2'b01, 0, 1);
        add(0, 0, 0, 1, 2'b01, 16'h0022, 16'h0000, 0, 16'h0020, 1, 10, 2'b11, 0, 1);
        add(0, 0, 0, 0, 2'b00, 16'h0000, 16'h0000, 1, 16'h0020, 0, 10, 2'b11, 0, 1);
        add(0, 1, 1, 1, 2'b01, 16'h0100, 16'h0000, 0, 16'h0100, 1, 11, 2'b11, 0, 1);
        add(0, 0, 0, 0, 2'b00, 16'h0000, 16'h0000, 1, 16'h0100, 0, 11, 2'b11, 0, 1);
        add(0, 0, 0, 0, 2'b00, 16'h0000, 16'h0000, 1, 16'h0100, 0, 11, 2'b11, 0, 1);
        add(0, 0, 1, 0, 2'b00, 16'h0000, 16'h0000, 0, 16'h0000, 0, 12, 2'b11, 1, 0);
        add(1, 1, 1, 1, 2'b01, 16'h0040, 16'h0000, 0, 16'h0000, 0, 12, 2'b11, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].start, vecs[i].halt, vecs[i].ready, vecs[i].rv,
                  vecs[i].rtype, vecs[i].rtgt, vecs[i].rpc);
            @(posedge clk); #1;
            check_out($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_pc, vecs[i].e_flush,
                      vecs[i].e_cnt, vecs[i].e_err, vecs[i].e_halted, vecs[i].e_rr,
                      !vecs[i].e_halted);
        end

        // Asynchronous reset in the middle of a redirect bubble.
        rst = 1'b1; #1; rst = 1'b0;
        drive(1, 0, 0, 0, 2'b00, 16'h0, 16'h0);
        @(posedge clk); #1;
        drive(0, 0, 1, 1, 2'b01, 16'h0080, 16'h0);
        @(posedge clk); #1;
        check_out("bubble_before_rst", 0, 16'h0080, 1, 1, 2'b00, 0, 1, 1);
        idle_inputs();
        #2; rst = 1'b1; #1;
        check_out("rst_mid_bubble", 0, 16'h0000, 0, 0, 2'b00, 0, 0, 1);
        rst = 1'b0;
        @(posedge clk); #1;
        check_out("idle_after_rst", 0, 16'h0000, 0, 0, 2'b00, 0, 0, 1);
        drive(1, 0, 0, 0, 2'b00, 16'h0, 16'h0);
        @(posedge clk); #1;
        check_out("restart", 1, 16'h0000, 0, 0, 2'b00, 0, 1, 1);

        // Randomized traffic against the reference model.
        rst = 1'b1; #1; rst = 1'b0;
        model_reset();
        check_model("rand_reset");
        for (int c = 0; c < 4000; c++) begin
            logic        st, hl, rdy, rv;
            logic [1:0]  ty;
            logic [15:0] tg, rp;
            if ((m_phase == PH_STOP && $urandom_range(0, 7) == 0) ||
                $urandom_range(0, 299) == 0) begin
                rst = 1'b1; #1; rst = 1'b0;
                model_reset();
                check_model("rand_rst");
            end
            st  = ($urandom_range(0, 3) == 0);
            hl  = ($urandom_range(0, 59) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 5) == 0);
            ty  = 2'($urandom_range(0, 3));
            tg  = 16'($urandom_range(0, 65535));
            if ($urandom_range(0, 1) == 0) tg[1:0] = 2'b00;
            rp  = 16'($urandom_range(0, 65535)) & 16'hFFFC;
            drive(st, hl, rdy, rv, ty, tg, rp);
            model_step(st, hl, rdy, rv, ty, tg, rp);
            @(posedge clk); #1;
            check_model($sformatf("rand%0d", c));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
